// File: rtl/screen_sel_if.sv
// Mouse/game control inputs, the three video sources and the selected
// VGA output of the screen arbiter, bundled as one port.
interface screen_sel_if;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        game_over;

    logic        menu_hsync;
    logic        menu_vsync;
    logic [11:0] menu_rgb;
    logic        game_hsync;
    logic        game_vsync;
    logic [11:0] game_rgb;
    logic        cred_hsync;
    logic        cred_vsync;
    logic [11:0] cred_rgb;

    logic        hsync_out;
    logic        vsync_out;
    logic [11:0] rgb_out;
    logic [1:0]  screen;
    logic        game_start;

    modport master (
        output mouse_xpos, mouse_ypos, mouse_left, game_over,
        output menu_hsync, menu_vsync, menu_rgb,
        output game_hsync, game_vsync, game_rgb,
        output cred_hsync, cred_vsync, cred_rgb,
        input  hsync_out, vsync_out, rgb_out, screen, game_start
    );

    modport slave (
        input  mouse_xpos, mouse_ypos, mouse_left, game_over,
        input  menu_hsync, menu_vsync, menu_rgb,
        input  game_hsync, game_vsync, game_rgb,
        input  cred_hsync, cred_vsync, cred_rgb,
        output hsync_out, vsync_out, rgb_out, screen, game_start
    );
endinterface

// File: rtl/screen_sel.sv
// Screen arbiter: picks the menu, game or credits video chain, switching only
// on frame boundaries of the visible source, then blanks for a few frames.
//
// state | meaning
// MENU  | menu chain on the pins; PLAY / CREDITS button clicks request a switch
// GAME  | game chain on the pins; game_over requests a return to the menu
// CRED  | credits chain on the pins; any click requests a return to the menu
module screen_sel #(
    parameter logic [11:0] PLAY_X0      = 12'd352,
    parameter logic [11:0] PLAY_X1      = 12'd447,
    parameter logic [11:0] PLAY_Y0      = 12'd250,
    parameter logic [11:0] PLAY_Y1      = 12'd289,
    parameter logic [11:0] CRED_X0      = 12'd352,
    parameter logic [11:0] CRED_X1      = 12'd447,
    parameter logic [11:0] CRED_Y0      = 12'd320,
    parameter logic [11:0] CRED_Y1      = 12'd359,
    parameter int unsigned BLANK_FRAMES = 1
) (
    input logic         clk,
    input logic         rst,
    screen_sel_if.slave bus
);
    typedef enum logic [1:0] {
        MENU = 2'd0,
        GAME = 2'd1,
        CRED = 2'd2
    } screen_t;

    localparam logic [3:0] BLANK_INIT = 4'(BLANK_FRAMES);

    screen_t     state;
    screen_t     target;
    logic        pending;
    logic [3:0]  blank_cnt;
    logic        left_q;
    logic        menu_vs_q;
    logic        game_vs_q;
    logic        cred_vs_q;

    logic        hsync_q;
    logic        vsync_q;
    logic [11:0] rgb_q;
    logic        game_start_q;

    logic        click;
    logic        in_play;
    logic        in_cred;
    logic        boundary;
    logic        commit;
    logic        req_valid;
    screen_t     req_target;
    logic        sel_hs;
    logic        sel_vs;
    logic [11:0] sel_rgb;
    logic [3:0]  blank_nxt;

    // Each source keeps its own vsync history so a freshly selected source
    // never sees a stale edge from the previous one.
    always_comb begin
        click   = bus.mouse_left & ~left_q;
        in_play = (bus.mouse_xpos >= PLAY_X0) && (bus.mouse_xpos <= PLAY_X1) &&
                  (bus.mouse_ypos >= PLAY_Y0) && (bus.mouse_ypos <= PLAY_Y1);
        in_cred = (bus.mouse_xpos >= CRED_X0) && (bus.mouse_xpos <= CRED_X1) &&
                  (bus.mouse_ypos >= CRED_Y0) && (bus.mouse_ypos <= CRED_Y1);

        sel_hs   = bus.menu_hsync;
        sel_vs   = bus.menu_vsync;
        sel_rgb  = bus.menu_rgb;
        boundary = bus.menu_vsync & ~menu_vs_q;
        case (state)
            GAME: begin
                sel_hs   = bus.game_hsync;
                sel_vs   = bus.game_vsync;
                sel_rgb  = bus.game_rgb;
                boundary = bus.game_vsync & ~game_vs_q;
            end
            CRED: begin
                sel_hs   = bus.cred_hsync;
                sel_vs   = bus.cred_vsync;
                sel_rgb  = bus.cred_rgb;
                boundary = bus.cred_vsync & ~cred_vs_q;
            end
            default: ;
        endcase

        req_valid  = 1'b0;
        req_target = MENU;
        case (state)
            MENU: begin
                if (click && in_play) begin
                    req_valid  = 1'b1;
                    req_target = GAME;
                end else if (click && in_cred) begin
                    req_valid  = 1'b1;
                    req_target = CRED;
                end
            end
            GAME:    req_valid = bus.game_over;
            CRED:    req_valid = click;
            default: ;
        endcase

        commit    = pending & boundary;
        blank_nxt = blank_cnt;
        if (commit) begin
            blank_nxt = BLANK_INIT;
        end else if (boundary && (blank_cnt != 4'd0)) begin
            blank_nxt = blank_cnt - 4'd1;
        end
    end

    // pending is registered, so a request latched on a boundary cycle can
    // only commit at a later boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= MENU;
            target       <= MENU;
            pending      <= 1'b0;
            blank_cnt    <= 4'd0;
            left_q       <= 1'b0;
            menu_vs_q    <= 1'b0;
            game_vs_q    <= 1'b0;
            cred_vs_q    <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            rgb_q        <= 12'h000;
            game_start_q <= 1'b0;
        end else begin
            left_q    <= bus.mouse_left;
            menu_vs_q <= bus.menu_vsync;
            game_vs_q <= bus.game_vsync;
            cred_vs_q <= bus.cred_vsync;

            if (commit) begin
                state   <= target;
                pending <= 1'b0;
            end else if (!pending && req_valid) begin
                pending <= 1'b1;
                target  <= req_target;
            end

            blank_cnt    <= blank_nxt;
            game_start_q <= commit && (target == GAME);
            hsync_q      <= sel_hs;
            vsync_q      <= sel_vs;
            rgb_q        <= (blank_nxt != 4'd0) ? 12'h000 : sel_rgb;
        end
    end

    assign bus.hsync_out  = hsync_q;
    assign bus.vsync_out  = vsync_q;
    assign bus.rgb_out    = rgb_q;
    assign bus.screen     = state;
    assign bus.game_start = game_start_q;
endmodule

// File: doc/screen_sel.md
Name: screen_sel

Overview:
- Top-level screen arbiter that sits directly downstream of the credits-screen stage and its sibling menu and game render chains.
- Runs a MENU/GAME/CRED state machine driven by mouse clicks and the game's game_over flag.
- Commits screen changes only at frame boundaries, then blanks for a programmable number of frames.
- Drives the single registered VGA output (hsync, vsync, rgb) to the pins.

Parameters:
- PLAY_X0, 352, left edge of PLAY button (inclusive, pixels)
- PLAY_X1, 447, right edge of PLAY button (inclusive)
- PLAY_Y0, 250, top edge of PLAY button (inclusive)
- PLAY_Y1, 289, bottom edge of PLAY button (inclusive)
- CRED_X0, 352, left edge of CREDITS button (inclusive)
- CRED_X1, 447, right edge of CREDITS button (inclusive)
- CRED_Y0, 320, top edge of CREDITS button (inclusive)
- CRED_Y1, 359, bottom edge of CREDITS button (inclusive)
- BLANK_FRAMES, 1, frames forced black after each committed switch (0 = none; max 15)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- mouse_xpos  in  12  mouse x, clk domain
- mouse_ypos  in  12  mouse y, clk domain
- mouse_left  in  1  left button level, clk domain
- game_over  in  1  level from game logic; high = match finished
- menu_hsync, menu_vsync  in  1 each  menu chain syncs
- menu_rgb  in  12  menu chain colour
- game_hsync, game_vsync  in  1 each  game chain syncs
- game_rgb  in  12  game chain colour
- cred_hsync, cred_vsync  in  1 each  credits chain syncs
- cred_rgb  in  12  credits chain colour
- hsync_out, vsync_out  out  1 each  registered selected syncs
- rgb_out  out  12  registered selected colour (or black while blanking)
- screen  out  2  committed screen: 0=MENU, 1=GAME, 2=CRED; 3 never driven
- game_start  out  1  one-cycle pulse on commit into GAME

Behaviour:
- Reset (rst low, async):
  - screen=MENU; pending cleared; blank counter=0.
  - hsync_out=0, vsync_out=0, rgb_out=0, game_start=0.
  - Click-edge and vsync history flops cleared.
- Click event: mouse_left rising edge, i.e. registered previous=0 and current=1. Holding the button produces one event only.
- Frame boundary: rising edge of the currently selected source's vsync, detected against a registered copy.
- Request rules, evaluated only while no request is pending:
  - MENU:
    - Click with PLAY_X0<=x<=PLAY_X1 and PLAY_Y0<=y<=PLAY_Y1 (12-bit unsigned compare) -> pending target GAME.
    - Click inside the CREDITS box -> pending target CRED.
    - Click elsewhere is ignored.
  - GAME: game_over high on any cycle -> pending target MENU. Clicks are ignored.
  - CRED: any click -> pending target MENU.
- While a request is pending, all new click and game_over events are dropped; the first event wins.
- Commit:
  - On the first frame boundary strictly after the cycle a request was latched: screen<=target, pending cleared, blank counter<=BLANK_FRAMES.
  - game_start=1 for exactly that cycle when target is GAME.
  - An event and a boundary in the same cycle latch the request; the request commits at the following boundary.
- Blanking: counter decrements at each frame boundary while nonzero. While nonzero, rgb_out=0; syncs still pass.
- Output mux: registered with 1-cycle latency from the source signals. The source is selected by the screen value before the commit cycle. The next cycle uses the new source, so syncs switch only at a boundary.
- Reset mid-pending: the request is discarded and the block returns to MENU.

Test Plan:
- Reset with rst=0 for 5 cycles, cred_rgb=12'hFFF, menu_rgb=12'h0A5 -> all outputs 0 during reset; one cycle after release rgb_out=12'h0A5 and screen=0.
- MENU, click at (400,270), then menu_vsync rising edge -> screen=1 and game_start=1 for one cycle at commit; rgb_out=0 for 1 frame, then follows game_rgb with 1-cycle latency.
- MENU, click at (100,100) and at (447,360) -> no request; screen stays 0 across 3 frames.
- MENU, click at (352,320), commit to CRED; then hold mouse_left high for 2 frames -> screen=2 after the 1st click; the held level produces no second event; release, click again, next cred_vsync rise -> screen=0.
- GAME, game_over=1 for 1 cycle -> screen=0 at the next game_vsync rise; game_start stays 0.
- MENU, PLAY click in the same cycle as a menu_vsync rising edge -> screen remains 0 through that edge and becomes 1 at the next rising edge.
